regfile_seq: RTL



---
 rtl/regfile_seq_pkg.sv | 15 +
 rtl/regfile_seq_mul.sv | 41 ++++
 rtl/regfile_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/regfile_seq_pkg.sv
// regfile_seq_pkg: shared opcodes, FSM states and default widths for the regfile sequencer
package regfile_seq_pkg;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 5;
  localparam int MUL_CYC_DEF = 16;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_ADDI = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_NOP  = 3'd7;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;
endpackage

// File: rtl/regfile_seq_mul.sv
// seq_mul16: iterative shift-add multiplier, low DW bits of the product, MUL_CYC steps
module seq_mul16 #(
  parameter int DW = 16,
  parameter int MUL_CYC = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] product
);
  logic [4:0] cnt;
  logic [DW-1:0] acc, ma, mb;
  // product is the accumulator including the current step, valid when done
  assign product = acc + (mb[0] ? ma : '0);
  assign done = busy && cnt == 5'(MUL_CYC - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt <= '0;
      acc <= '0;
      ma <= '0;
      mb <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      acc <= '0;
      ma <= a;
      mb <= b;
    end else if (busy) begin
      acc <= product;
      ma <= ma << 1;
      mb <= mb >> 1;
      cnt <= done ? '0 : cnt + 5'd1;
      busy <= !done;
    end
  end
endmodule

// File: rtl/regfile_seq.sv
// regfile_seq: multi-cycle read/execute/writeback sequencer driving the 32x16 register file
module regfile_seq
  import regfile_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int MUL_CYC = MUL_CYC_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    opcode,
  input  logic [AW-1:0] rd,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic [DW-1:0] imm,
  output logic          rf_write,
  output logic [AW-1:0] rf_wrAddr,
  output logic [DW-1:0] rf_wrData,
  output logic [AW-1:0] rf_rdAddrA,
  input  logic [DW-1:0] rf_rdDataA,
  output logic [AW-1:0] rf_rdAddrB,
  input  logic [DW-1:0] rf_rdDataB,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          zero
);
  state_t state, nxt;
  logic [2:0] op_q;
  logic [AW-1:0] rd_q, rs_q, rt_q;
  logic [DW-1:0] imm_q, op_a, op_b, res, alu, mul_p;
  logic accept, is_mul, mul_start, mul_busy, mul_done, exec_end;
  assign instr_ready = state == S_IDLE && !rst;
  assign accept = instr_valid && instr_ready;
  assign busy = state != S_IDLE;
  assign is_mul = op_q == OP_MUL;
  assign exec_end = state == S_EXEC && (!is_mul || mul_done);
  // reset is gated in so an instruction interrupted in WB never writes
  assign done = state == S_WB && !rst;
  assign rf_write = done && rd_q != '0 && op_q != OP_NOP;
  assign rf_wrAddr = rd_q;
  assign rf_wrData = res;
  assign rf_rdAddrA = state == S_IDLE ? '0 : rs_q;
  assign rf_rdAddrB = state == S_IDLE ? '0 : rt_q;
  assign mul_start = state == S_READ && is_mul && !mul_busy;
  seq_mul16 #(.DW(DW), .MUL_CYC(MUL_CYC)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(mul_start),
    .a(rf_rdDataA),
    .b(rf_rdDataB),
    .busy(mul_busy),
    .done(mul_done),
    .product(mul_p)
  );
  always_comb begin
    alu = '0;
    case (op_q)
      OP_ADD:  alu = op_a + op_b;
      OP_SUB:  alu = op_a - op_b;
      OP_AND:  alu = op_a & op_b;
      OP_OR:   alu = op_a | op_b;
      OP_XOR:  alu = op_a ^ op_b;
      OP_ADDI: alu = op_a + imm_q;
      default: alu = '0;
    endcase
  end
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = accept ? S_READ : S_IDLE;
      S_READ:  nxt = S_EXEC;
      S_EXEC:  nxt = exec_end ? S_WB : S_EXEC;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? S_IDLE : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0;
      rd_q <= '0;
      rs_q <= '0;
      rt_q <= '0;
      imm_q <= '0;
      op_a <= '0;
      op_b <= '0;
      res <= '0;
      result <= '0;
      zero <= 1'b1;
    end else begin
      if (accept) begin
        op_q <= opcode;
        rd_q <= rd;
        rs_q <= rs;
        rt_q <= rt;
        imm_q <= imm;
      end
      if (state == S_READ) begin
        op_a <= rf_rdDataA;
        op_b <= rf_rdDataB;
      end
      if (exec_end) res <= is_mul ? mul_p : alu;
      if (state == S_WB) begin
        result <= res;
        zero <= res == '0;
      end
    end
  end
endmodule
